sam_bus_memory: RTL and testbench
=================================

Name: sam_bus_memory

Overview:
- Synthesizable memory slave on the SAM multiplexed CPU bus. It sits directly downstream of the Toplevel Bus_Out/ALE/En/Rw interface and produces Bus_In.
- It latches the address on ALE and serves byte reads and writes from a DEPTH x 8 RAM.
- A byte-stream loader fills program memory after reset while the CPU is held via cpu_hold, which is wired to the CPU's pause input.

Parameters:
- DEPTH, 64, number of RAM bytes; must be a power of two and no more than 256.
- AW, 6, RAM index width; equals log2(DEPTH).
- LOAD_ON_RESET, 1, when 1 the block enters LOAD after reset; when 0 it enters RUN.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- Bus_Out  in  8  CPU output bus: address when ALE=1, write data otherwise.
- ALE  in  1  address latch enable.
- En  in  1  access strobe.
- Rw  in  1  access direction: 1 = read, 0 = write.
- Bus_In  out  8  registered read data to the CPU.
- rd_valid  out  1  one-cycle pulse: Bus_In was updated by a read this cycle.
- cpu_hold  out  1  high while in LOAD; drives CPU pause.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  marks the final loader byte; qualified by ld_valid.
- ld_ready  out  1  loader may transfer this cycle.
- addr_err  out  1  sticky flag: a CPU access targeted an address of DEPTH or above.

Behaviour:
- Reset, synchronous: addr_q=0, Bus_In=8'h00, rd_valid=0, addr_err=0, ld_ptr=0.
  - State after reset is LOAD if LOAD_ON_RESET=1, otherwise RUN.
  - RAM contents are not reset.
  - rst has priority over every other event.
- States: LOAD, RUN. Outputs per state:
  - LOAD: cpu_hold=1, ld_ready=1.
  - RUN: cpu_hold=0, ld_ready=0.
- LOAD state:
  - Each edge with ld_valid=1 writes ld_data to mem[ld_ptr], then ld_ptr increments.
  - Transition to RUN when the transfer has ld_last=1, or when ld_ptr==DEPTH-1 is written.
  - ld_ptr never wraps.
  - CPU En/ALE activity in LOAD is ignored: no RAM change, no Bus_In change, no addr_err.
- RUN, address latch: ALE=1 at an edge sets addr_q<=Bus_Out (full 8 bits).
- RUN, effective address: eff = Bus_Out if ALE=1 this edge, otherwise addr_q. This bypass lets ALE and En arrive in the same cycle.
  - Exception: when ALE and En are both high, Bus_Out is the address, so a same-edge write stores Bus_Out, which is the address value. This is the decided behaviour; the CPU must not issue it.
- RUN, read (En=1, Rw=1):
  - Bus_In<=mem[eff[AW-1:0]] and rd_valid=1 on the next cycle (1-cycle latency).
  - Bus_In holds its value until the next read.
- RUN, write (En=1, Rw=0): mem[eff[AW-1:0]]<=Bus_Out at the edge. A read of the same address on the next cycle returns the new data.
- Out-of-range address (eff>=DEPTH):
  - Write is dropped.
  - Read returns 8'h00 with rd_valid=1.
  - addr_err is set and stays set until rst.
- En=0: no access; Bus_In holds; rd_valid=0.
- Reset during LOAD or RUN: returns to the reset state. A partial load is abandoned and ld_ptr=0; RAM keeps the bytes already written.

Decomposition:
- Shared package (sam_pkg):
  - bus width constant BUS_W=8.
  - state enumeration SAM_MEM_LOAD / SAM_MEM_RUN.
  - Rw encoding constants RW_READ=1'b1, RW_WRITE=1'b0.
- One sub-module, sam_ram_sp: single-port synchronous RAM, DEPTH x 8.
  - Inputs: we, addr[AW-1:0], wdata.
  - Output: registered rdata.
  - The write port is muxed between loader and CPU by state.
- The FSM, address latch and error logic live in the top block.

Test Plan:
- Load after reset: rst 2 cycles; stream 0x17, 0x61, 0x01 with ld_last on 0x01 -> mem[0..2]=17,61,01; cpu_hold falls on the edge after the last byte; ld_ready=0 afterwards.
- Read with latency: RUN; ALE with Bus_Out=0x01, then En=1, Rw=1 -> next cycle Bus_In=0x61, rd_valid pulses for exactly 1 cycle.
- Write then read: ALE 0x07; write Bus_Out=0xFD; then ALE 0x07 and read -> Bus_In=0xFD. Same-cycle ALE+En read of 0x02 -> Bus_In=0x01 via bypass.
- Out of range: ALE 0x40; write 0xAA; read -> no RAM change (mem[0] still 0x17), Bus_In=0x00, addr_err=1 and stays 1 until rst.
- Loader full fill: 64 bytes with no ld_last -> enters RUN after byte 63; a 65th ld_valid is ignored.
- Reset mid-load: rst after 10 loader bytes -> ld_ptr=0, cpu_hold=1; reload 0x33 -> mem[0]=0x33, mem[1..9] keep the old bytes. CPU En during LOAD changes nothing.

Source files
------------

// File: rtl/sam_pkg.sv
// Shared constants and types for the SAM bus memory slave.
package sam_pkg;

  localparam int unsigned BUS_W = 8;

  typedef enum logic {
    SAM_MEM_LOAD = 1'b0,
    SAM_MEM_RUN  = 1'b1
  } sam_mem_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/sam_ram_sp.sv
// Single-port synchronous RAM with a registered read port that can force zero.
module sam_ram_sp
  import sam_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic             rd_zero,
  input  logic [AW-1:0]    addr,
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] rdata
);

  logic [BUS_W-1:0] mem [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read data; holds until the next read, zero for rejected addresses.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rd_zero ? '0 : mem[addr];
  end

endmodule

// File: rtl/sam_bus_memory.sv
// Memory slave on the SAM multiplexed bus with a post-reset byte-stream loader.
module sam_bus_memory
  import sam_pkg::*;
#(
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned AW            = 6,
  parameter bit          LOAD_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Bus_Out,
  input  logic       ALE,
  input  logic       En,
  input  logic       Rw,
  output logic [7:0] Bus_In,
  output logic       rd_valid,
  output logic       cpu_hold,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       addr_err
);

  localparam sam_mem_state_e RESET_STATE = LOAD_ON_RESET ? SAM_MEM_LOAD : SAM_MEM_RUN;
  localparam logic [AW-1:0]  LAST_IDX    = AW'(DEPTH - 1);

  sam_mem_state_e   state_q, state_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic [AW-1:0]    ld_ptr_q, ld_ptr_d;
  logic             rd_valid_d;
  logic             addr_err_d;
  logic [BUS_W-1:0] eff_c;
  logic             oor_c;
  logic             ram_we, ram_re, ram_zero;
  logic [AW-1:0]    ram_addr;
  logic [BUS_W-1:0] ram_wdata;

  // Next state, loader pointer, address latch and RAM port muxing.
  always_comb begin
    state_d    = state_q;
    ld_ptr_d   = ld_ptr_q;
    addr_d     = addr_q;
    rd_valid_d = 1'b0;
    addr_err_d = addr_err;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_zero   = 1'b0;
    ram_addr   = ld_ptr_q;
    ram_wdata  = ld_data;
    eff_c      = ALE ? Bus_Out : addr_q;
    oor_c      = {1'b0, eff_c} >= 9'(DEPTH);

    case (state_q)
      SAM_MEM_LOAD: begin
        if (ld_valid) begin
          ram_we = 1'b1;
          if (ld_last || ld_ptr_q == LAST_IDX) state_d = SAM_MEM_RUN;
          if (ld_ptr_q != LAST_IDX) ld_ptr_d = ld_ptr_q + AW'(1);
        end
      end
      SAM_MEM_RUN: begin
        if (ALE) addr_d = Bus_Out;
        ram_addr  = eff_c[AW-1:0];
        ram_wdata = Bus_Out;
        if (En) begin
          if (oor_c) addr_err_d = 1'b1;
          if (Rw == RW_READ) begin
            ram_re     = 1'b1;
            ram_zero   = oor_c;
            rd_valid_d = 1'b1;
          end else begin
            ram_we = !oor_c;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // State and control registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RESET_STATE;
      addr_q   <= '0;
      ld_ptr_q <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ld_ptr_q <= ld_ptr_d;
      rd_valid <= rd_valid_d;
      addr_err <= addr_err_d;
    end
  end

  assign cpu_hold = (state_q == SAM_MEM_LOAD);
  assign ld_ready = (state_q == SAM_MEM_LOAD);

  sam_ram_sp #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .re      (ram_re),
    .rd_zero (ram_zero),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (Bus_In)
  );

endmodule

// File: tb/tb_sam_bus_memory.sv
// Directed bench for sam_bus_memory: loader, reads, writes, bypass, range errors, resets.
module tb_sam_bus_memory;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] Bus_Out = 8'h00;
  logic       ALE = 1'b0;
  logic       En = 1'b0;
  logic       Rw = 1'b1;
  logic [7:0] Bus_In;
  logic       rd_valid;
  logic       cpu_hold;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic       addr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sam_bus_memory #(.DEPTH(64), .AW(6), .LOAD_ON_RESET(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .Bus_Out  (Bus_Out),
    .ALE      (ALE),
    .En       (En),
    .Rw       (Rw),
    .Bus_In   (Bus_In),
    .rd_valid (rd_valid),
    .cpu_hold (cpu_hold),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .addr_err (addr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Same-edge ALE+En read; result visible after the step.
  task automatic cpu_read(input logic [7:0] a);
    ALE = 1'b1; En = 1'b1; Rw = 1'b1; Bus_Out = a;
    step();
    ALE = 1'b0; En = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
    total++; if (Bus_In !== 8'h00) begin bad++; $display("FAIL reset_bus_in got=%h exp=00", Bus_In); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
    rst = 1'b0;
  endtask

  task automatic test_load();
    load_byte(8'h17, 1'b0);
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL load_hold_mid got=%b exp=1", cpu_hold); end
    load_byte(8'h61, 1'b0);
    load_byte(8'h01, 1'b1);
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL load_hold_end got=%b exp=0", cpu_hold); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL load_ready_end got=%b exp=0", ld_ready); end
  endtask

  task automatic test_read_latency();
    ALE = 1'b1; Bus_Out = 8'h01;
    step();
    ALE = 1'b0; En = 1'b1; Rw = 1'b1; Bus_Out = 8'hEE;
    step();
    total++; if (Bus_In !== 8'h61) begin bad++; $display("FAIL rd_latency_data got=%h exp=61", Bus_In); end
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_latency_valid got=%b exp=1", rd_valid); end
    En = 1'b0;
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_pulse got=%b exp=0", rd_valid); end
    total++; if (Bus_In !== 8'h61) begin bad++; $display("FAIL rd_hold got=%h exp=61", Bus_In); end
    cpu_read(8'h00);
    total++; if (Bus_In !== 8'h17) begin bad++; $display("FAIL rd_mem0 got=%h exp=17", Bus_In); end
  endtask

  task automatic test_write_read();
    ALE = 1'b1; Bus_Out = 8'h07;
    step();
    ALE = 1'b0; En = 1'b1; Rw = 1'b0; Bus_Out = 8'hFD;
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL wr_no_valid got=%b exp=0", rd_valid); end
    En = 1'b0; ALE = 1'b1; Bus_Out = 8'h07;
    step();
    ALE = 1'b0; En = 1'b1; Rw = 1'b1; Bus_Out = 8'h00;
    step();
    En = 1'b0;
    total++; if (Bus_In !== 8'hFD) begin bad++; $display("FAIL wr_then_rd got=%h exp=fd", Bus_In); end
    cpu_read(8'h02);
    total++; if (Bus_In !== 8'h01) begin bad++; $display("FAIL bypass_rd got=%h exp=01", Bus_In); end
  endtask

  task automatic test_out_of_range();
    ALE = 1'b1; Bus_Out = 8'h40;
    step();
    ALE = 1'b0; En = 1'b1; Rw = 1'b0; Bus_Out = 8'hAA;
    step();
    Rw = 1'b1;
    step();
    En = 1'b0;
    total++; if (Bus_In !== 8'h00) begin bad++; $display("FAIL oor_rd_data got=%h exp=00", Bus_In); end
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL oor_rd_valid got=%b exp=1", rd_valid); end
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", addr_err); end
    cpu_read(8'h00);
    total++; if (Bus_In !== 8'h17) begin bad++; $display("FAIL oor_no_alias got=%h exp=17", Bus_In); end
    step(); step();
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_sticky got=%b exp=1", addr_err); end
  endtask

  task automatic test_full_fill();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL fill_err_cleared got=%b exp=0", addr_err); end
    for (int i = 0; i < 64; i++) begin
      load_byte(8'(i * 3 + 5), 1'b0);
      if (i == 62) begin
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL fill_hold_62 got=%b exp=1", cpu_hold); end
      end
    end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL fill_hold_63 got=%b exp=0", cpu_hold); end
    load_byte(8'hEE, 1'b0);
    cpu_read(8'h00);
    total++; if (Bus_In !== 8'h05) begin bad++; $display("FAIL fill_mem0 got=%h exp=05", Bus_In); end
    cpu_read(8'h3F);
    total++; if (Bus_In !== 8'hC2) begin bad++; $display("FAIL fill_mem63 got=%h exp=c2", Bus_In); end
  endtask

  task automatic test_reset_mid_load();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) load_byte(8'(8'h80 + i), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL midrst_hold got=%b exp=1", cpu_hold); end
    ALE = 1'b1; Bus_Out = 8'h05;
    step();
    ALE = 1'b0; En = 1'b1; Rw = 1'b0; Bus_Out = 8'h5A;
    step();
    ALE = 1'b1; Rw = 1'b1; Bus_Out = 8'h80;
    step();
    ALE = 1'b0; En = 1'b0;
    total++; if (Bus_In !== 8'h00) begin bad++; $display("FAIL load_cpu_bus_in got=%h exp=00", Bus_In); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL load_cpu_valid got=%b exp=0", rd_valid); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL load_cpu_err got=%b exp=0", addr_err); end
    load_byte(8'h33, 1'b1);
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL reload_hold got=%b exp=0", cpu_hold); end
    cpu_read(8'h00);
    total++; if (Bus_In !== 8'h33) begin bad++; $display("FAIL reload_mem0 got=%h exp=33", Bus_In); end
    cpu_read(8'h01);
    total++; if (Bus_In !== 8'h81) begin bad++; $display("FAIL reload_mem1 got=%h exp=81", Bus_In); end
    cpu_read(8'h05);
    total++; if (Bus_In !== 8'h85) begin bad++; $display("FAIL reload_mem5 got=%h exp=85", Bus_In); end
    cpu_read(8'h09);
    total++; if (Bus_In !== 8'h89) begin bad++; $display("FAIL reload_mem9 got=%h exp=89", Bus_In); end
    cpu_read(8'h0A);
    total++; if (Bus_In !== 8'h23) begin bad++; $display("FAIL reload_mem10 got=%h exp=23", Bus_In); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_read_latency();
    test_write_read();
    test_out_of_range();
    test_full_fill();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
